// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
// Shared types and constants for the data-port SRAM responder:
//   - access size encodings (informational only; the master extracts lanes)
//   - response queue entry {rdata, cnt}
//   - LFSR seed/taps and step function used by the optional random-delay mode
// Optional feature macro: DATA_SRAM_RANDOM_DELAY_EN widens the per-entry
// countdown so up to 7 extra cycles of random latency fit.
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

`ifdef DATA_SRAM_RANDOM_DELAY_EN
  // LATENCY-1 (max 6) plus up to 7 random cycles needs 4 bits.
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 3;
`endif

  typedef struct packed {
    logic [31:0]      rdata;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_sram_responder_queue.sv
// -----------------------------------------------------------------------------
// sram_resp_queue
// DEPTH-entry circular FIFO of pending responses. Each entry holds its response
// data and a countdown; the head drives data_ok once its countdown is zero and
// pops on that same edge. Non-head entries that reach zero simply wait.
//
// Load data comes from a block RAM with a registered read, so it is only
// available one cycle after the push. The entry is pushed with rdata=0 and
// patched from fill_data on the following edge; if the head is that very entry
// in the patch cycle (LATENCY=1) the output bypasses fill_data directly.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push            enqueue push_entry at the tail
//   push_fill       the pushed entry is a load; patch rdata next cycle
//   push_entry      {rdata, cnt} for the new entry
//   fill_data       registered RAM read data (valid the cycle after a load push)
//   count           number of queued entries
//   data_ok         head entry is ready (masked during reset)
//   rdata           head response data when data_ok, else 0
// -----------------------------------------------------------------------------
module sram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_fill,
  input  entry_t      push_entry,
  input  logic [31:0] fill_data,
  output logic [2:0]  count,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  logic [1:0] head_reg;
  logic [1:0] tail_reg;
  logic [1:0] fill_slot_reg;
  logic       fill_pending_reg;
  logic [2:0] count_reg;
  logic [2:0] count_next;
  logic       pop;
  logic       head_ready;

  // Flat view of all four possible slots so the head mux index is full width.
  entry_t slot [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < DEPTH) begin : g_used
        entry_t entry_reg;

        always_ff @(posedge clk) begin
          if (reset) begin
            entry_reg <= '0;
          end else if (push && (tail_reg == 2'(gi))) begin
            entry_reg <= push_entry;
          end else begin
            // Free slots may also count down; a push overwrites them anyway.
            if (entry_reg.cnt != '0) begin
              entry_reg.cnt <= entry_reg.cnt - CNT_W'(1);
            end
            if (fill_pending_reg && (fill_slot_reg == 2'(gi))) begin
              entry_reg.rdata <= fill_data;
            end
          end
        end

        assign slot[gi] = entry_reg;
      end else begin : g_unused
        assign slot[gi] = '0;
      end
    end
  endgenerate

  assign head_ready = (count_reg != 3'd0) && (slot[head_reg].cnt == '0);
  assign data_ok    = ~reset & head_ready;
  assign pop        = data_ok;
  assign count      = count_reg;

  always_comb begin
    rdata = 32'd0;
    if (data_ok) begin
      if (fill_pending_reg && (fill_slot_reg == head_reg)) begin
        rdata = fill_data;
      end else begin
        rdata = slot[head_reg].rdata;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg         <= 2'd0;
      tail_reg         <= 2'd0;
      count_reg        <= 3'd0;
      fill_pending_reg <= 1'b0;
      fill_slot_reg    <= 2'd0;
    end else begin
      if (push) begin
        tail_reg      <= (tail_reg == LAST) ? 2'd0 : tail_reg + 2'd1;
        fill_slot_reg <= tail_reg;
      end
      if (pop) begin
        head_reg <= (head_reg == LAST) ? 2'd0 : head_reg + 2'd1;
      end
      fill_pending_reg <= push & push_fill;
      count_reg        <= count_next;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
// Memory-side responder for the CPU data port: a byte-writable word array
// behind a req/addr_ok request handshake with in-order data_ok responses after
// LATENCY cycles, up to DEPTH requests outstanding.
//
// Optional feature macro: DATA_SRAM_RANDOM_DELAY_EN
//   defined   -> 16-bit LFSR randomly withholds addr_ok and adds 0..7 cycles
//                of extra latency per request
//   undefined -> addr_ok limited only by queue occupancy, fixed latency
//
// Parameters:
//   ADDR_WIDTH  word-index bits (2^ADDR_WIDTH 32-bit words)
//   LATENCY     accept-to-data_ok cycles, 1..7
//   DEPTH       max outstanding requests, 1..4
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   req         request present
//   wr          1 = store, 0 = load
//   size        access size (informational, unused)
//   wstrb       byte write enables for stores
//   addr        byte address; word index is addr[ADDR_WIDTH+1:2]
//   wdata       lane-replicated store data
//   addr_ok     request accepted when req & addr_ok
//   data_ok     response valid (no back-pressure)
//   rdata       load data when data_ok, otherwise 0
// -----------------------------------------------------------------------------
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         WORDS   = 1 << ADDR_WIDTH;
  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  logic [ADDR_WIDTH-1:0] index;
  logic [2:0]            count;
  logic                  gate;
  logic                  accept;
  logic                  store_acc;
  logic                  load_acc;
  logic [CNT_W-1:0]      push_cnt;
  entry_t                push_entry;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  // Upper address bits alias, byte offset and size are not needed here.
  assign index     = addr[ADDR_WIDTH+1:2];
  assign unused_ok = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

  // addr_ok looks only at registered occupancy, never at a concurrent pop.
  assign addr_ok   = ~reset & (count < DEPTH_L) & gate;
  assign accept    = req & addr_ok;
  assign store_acc = accept & wr;
  assign load_acc  = accept & ~wr;

`ifdef DATA_SRAM_RANDOM_DELAY_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign gate     = ~lfsr_reg[0];
  assign push_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_reg[3:1]);
`else
  assign gate     = 1'b1;
  assign push_cnt = CNT_W'(LATENCY - 1);
`endif

  // Store responses carry rdata=0; load data is patched in by the queue.
  assign push_entry = '{rdata: 32'd0, cnt: push_cnt};

  // One byte-wide RAM per lane: per-lane write enable, registered read.
  // The read captures pre-write contents; a store and a load are never
  // accepted in the same cycle, so there is no same-address conflict.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (store_acc && wstrb[gi]) begin
          lane_mem[index] <= wdata[gi*8 +: 8];
        end
        if (load_acc) begin
          rd_byte_reg <= lane_mem[index];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  sram_resp_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_fill  (load_acc),
    .push_entry (push_entry),
    .fill_data  (rd_word),
    .count      (count),
    .data_ok    (data_ok),
    .rdata      (rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic        clk;
  // Instance A: LATENCY=1, DEPTH=2
  logic        reset_a, req_a, wr_a;
  logic [1:0]  size_a;
  logic [3:0]  wstrb_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        addr_ok_a, data_ok_a;
  // Instance B: LATENCY=3, DEPTH=2, small array
  logic        reset_b, req_b, wr_b;
  logic [1:0]  size_b;
  logic [3:0]  wstrb_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic        addr_ok_b, data_ok_b;

  int n_checks = 0;
  int n_errors = 0;

  data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1), .DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .wr(wr_a), .size(size_a),
    .wstrb(wstrb_a), .addr(addr_a), .wdata(wdata_a),
    .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
  );

  data_sram_responder #(.ADDR_WIDTH(8), .LATENCY(3), .DEPTH(2)) u_dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .wr(wr_b), .size(size_b),
    .wstrb(wstrb_b), .addr(addr_b), .wdata(wdata_b),
    .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on A (LATENCY=1): accepted immediately, answered next cycle.
  task automatic xact_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp);
    req_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d; wstrb_a = s;
    @(negedge clk);
    check("a_addr_ok", {31'd0, addr_ok_a}, 32'd1);
    check("a_dok_idle", {31'd0, data_ok_a}, 32'd0);
    check("a_rdata_idle", rdata_a, 32'd0);
    step();
    req_a = 1'b0;
    @(negedge clk);
    check("a_data_ok", {31'd0, data_ok_a}, 32'd1);
    check("a_rdata", rdata_a, exp);
    $display("A %s addr=%h wdata=%h wstrb=%b rdata=%h exp=%h",
             w ? "st" : "ld", a, d, s, rdata_a, exp);
    step();
  endtask

  // One request on B with a bounded wait for the response; latency must be 3.
  task automatic xact_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp);
    int lat;
    logic [31:0] got;
    lat = 0;
    got = 32'd0;
    req_b = 1'b1; wr_b = w; addr_b = a; wdata_b = d; wstrb_b = s;
    @(negedge clk);
    check("b_addr_ok", {31'd0, addr_ok_b}, 32'd1);
    step();
    req_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (data_ok_b) begin
        lat = k;
        got = rdata_b;
        break;
      end
    end
    check("b_latency", lat, 32'd3);
    check("b_rdata", got, exp);
    $display("B %s addr=%h wdata=%h lat=%0d rdata=%h exp=%h",
             w ? "st" : "ld", a, d, lat, got, exp);
    step();
  endtask

  logic [31:0] model [16];
  logic [31:0] exp_q [$];
  int          t_q [$];

  initial begin
    logic        exp_aok [9];
    logic        exp_dok [9];
    logic [31:0] vals [4];
    logic [31:0] e;
    int          acc, r, idx, ops, lat, t;

    reset_a = 1'b1; req_a = 1'b0; wr_a = 1'b0; size_a = 2'd2; wstrb_a = 4'h0;
    addr_a = 32'd0; wdata_a = 32'd0;
    reset_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; size_b = 2'd2; wstrb_b = 4'h0;
    addr_b = 32'd0; wdata_b = 32'd0;

    // Reset state
    step(); step();
    req_a = 1'b1;
    @(negedge clk);
    check("rst_addr_ok", {31'd0, addr_ok_a}, 32'd0);
    check("rst_data_ok", {31'd0, data_ok_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    step();
    req_a = 1'b0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    check("post_rst_addr_ok", {31'd0, addr_ok_a}, 32'd1);
    check("post_rst_data_ok", {31'd0, data_ok_a}, 32'd0);
    step();

    // Full-word store/load, byte strobes, aliasing, zero strobe
    xact_a(1'b1, 32'h100, 32'h11223344, 4'b1111, 32'd0);
    xact_a(1'b0, 32'h100, 32'd0, 4'b0000, 32'h11223344);
    xact_a(1'b1, 32'h102, 32'hAAAAAAAA, 4'b0100, 32'd0);
    xact_a(1'b0, 32'h100, 32'd0, 4'b0000, 32'h11AA3344);
    xact_a(1'b0, 32'h10000103, 32'd0, 4'b0000, 32'h11AA3344);
    xact_a(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 32'd0);
    xact_a(1'b0, 32'h100, 32'd0, 4'b0000, 32'h11AA3344);

    // Back-to-back loads: three consecutive data_ok cycles
    xact_a(1'b1, 32'h0, 32'd1, 4'b1111, 32'd0);
    xact_a(1'b1, 32'h4, 32'd2, 4'b1111, 32'd0);
    xact_a(1'b1, 32'h8, 32'd3, 4'b1111, 32'd0);
    req_a = 1'b1; wr_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_a = 32'(i * 4);
      @(negedge clk);
      check($sformatf("b2b_aok%0d", i), {31'd0, addr_ok_a}, 32'd1);
      check($sformatf("b2b_dok%0d", i), {31'd0, data_ok_a}, (i > 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_rdata%0d", i), rdata_a, 32'(i));
      $display("A b2b cycle %0d data_ok=%0d rdata=%h", i, data_ok_a, rdata_a);
      step();
    end
    req_a = 1'b0;
    @(negedge clk);
    check("b2b_dok3", {31'd0, data_ok_a}, 32'd1);
    check("b2b_rdata3", rdata_a, 32'd3);
    step();
    @(negedge clk);
    check("b2b_idle", {31'd0, data_ok_a}, 32'd0);
    step();

    // B: preload, then throttling with req held high (DEPTH=2, LATENCY=3)
    vals = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
    for (int i = 0; i < 4; i++) xact_b(1'b1, 32'(i * 4), vals[i], 4'b1111, 32'd0);
    exp_aok = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_dok = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    acc = 0;
    r = 0;
    for (int c = 0; c < 9; c++) begin
      req_b = (acc < 4); wr_b = 1'b0; addr_b = 32'(acc * 4);
      @(negedge clk);
      check($sformatf("thr_aok%0d", c), {31'd0, addr_ok_b}, {31'd0, exp_aok[c]});
      check($sformatf("thr_dok%0d", c), {31'd0, data_ok_b}, {31'd0, exp_dok[c]});
      if (exp_dok[c]) begin
        check($sformatf("thr_rdata%0d", c), rdata_b, vals[r]);
        r++;
      end else begin
        check($sformatf("thr_rdata_idle%0d", c), rdata_b, 32'd0);
      end
      $display("B thr cycle %0d addr_ok=%0d data_ok=%0d rdata=%h",
               c, addr_ok_b, data_ok_b, rdata_b);
      if (req_b && addr_ok_b) acc++;
      step();
    end
    req_b = 1'b0;

    // Reset with two requests outstanding
    req_b = 1'b1; wr_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr_b = 32'(i * 4);
      @(negedge clk);
      check($sformatf("rst_pre_aok%0d", i), {31'd0, addr_ok_b}, 32'd1);
      step();
    end
    req_b = 1'b0;
    reset_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_b_addr_ok", {31'd0, addr_ok_b}, 32'd0);
      check("rst_b_data_ok", {31'd0, data_ok_b}, 32'd0);
      step();
    end
    reset_b = 1'b0;
    @(negedge clk);
    check("rst_b_release_aok", {31'd0, addr_ok_b}, 32'd1);
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_b_no_dok", {31'd0, data_ok_b}, 32'd0);
      step();
    end
    $display("B reset with 2 outstanding: no stale responses");
    xact_b(1'b0, 32'h4, 32'd0, 4'b0000, 32'hB1);

    // Random loads/stores on B against a scoreboard
    ops = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (ops < 16) begin
        req_b = 1'b1; wr_b = 1'b1; idx = ops; wstrb_b = 4'hF;
      end else if (ops < 200) begin
        req_b = ($urandom_range(0, 3) != 0);
        wr_b = 1'($urandom_range(0, 1));
        idx = $urandom_range(0, 15);
        wstrb_b = 4'($urandom);
      end else begin
        req_b = 1'b0; idx = 0;
      end
      addr_b = ($urandom & 32'hFFFFFC00) | 32'(idx << 2) | ($urandom & 32'h3);
      wdata_b = $urandom;
      @(negedge clk);
      if (data_ok_b) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          t = t_q.pop_front();
          lat = cyc - t;
          check("sb_rdata", rdata_b, e);
          check("sb_lat_range", {31'd0, (lat >= 3 && lat <= 10)}, 32'd1);
          $display("B sb resp lat=%0d rdata=%h exp=%h", lat, rdata_b, e);
        end
      end
      if (req_b && addr_ok_b) begin
        if (wr_b) begin
          e = 32'd0;
          for (int l = 0; l < 4; l++)
            if (wstrb_b[l]) model[idx][l*8 +: 8] = wdata_b[l*8 +: 8];
        end else begin
          e = model[idx];
        end
        exp_q.push_back(e);
        t_q.push_back(cyc);
        ops++;
      end
      step();
      if (ops >= 200 && exp_q.size() == 0) break;
    end
    req_b = 1'b0;
    check("sb_ops", 32'(ops), 32'd200);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
